// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes words over valid/ready and shifts them MSB-first into a tile's ccff chain.
// Optional readback of the old chain content from ccff_tail is built only when CCFF_READBACK_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 22,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int WC_W = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  bcnt;
  logic [WC_W-1:0]   wcnt;
  logic [WORD_W-1:0] sr;
  logic              accept;
  logic              last_bit;
  logic              word_end;

  // Bits still to take from the next word: a full word, or the remainder of the chain.
  function automatic logic [WC_W-1:0] word_bits(input logic [CNT_W-1:0] b);
    logic [CNT_W:0] left;
    left = (CNT_W+1)'(CHAIN_LEN) - {1'b0, b};
    if (left >= (CNT_W+1)'(WORD_W)) return WC_W'(WORD_W);
    return WC_W'(left);
  endfunction

  assign accept   = (state == S_FETCH) && cfg_valid;
  assign last_bit = (bcnt == LAST_BIT);
  assign word_end = (wcnt == WC_W'(1));

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state <= S_IDLE;
      bcnt  <= '0;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            bcnt  <= '0;
          end
        end
        S_FETCH: begin
          if (cfg_valid) begin
            wcnt  <= word_bits(bcnt);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcnt <= bcnt + CNT_W'(1);
          wcnt <= wcnt - WC_W'(1);
          if (last_bit)      state <= S_DONE;
          else if (word_end) state <= S_FETCH;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  // Shift register is pure datapath; its value is only visible through the SHIFT-gated head.
  always_ff @(posedge prog_clk) begin
    if (accept)                sr <= cfg_data;
    else if (state == S_SHIFT) sr <= {sr[WORD_W-2:0], 1'b0};
  end

  assign cfg_ready     = (state == S_FETCH);
  assign ccff_shift_en = (state == S_SHIFT);
  assign ccff_head     = ccff_shift_en & sr[WORD_W-1];
  assign busy          = (state == S_FETCH) || (state == S_SHIFT);
  assign done          = (state == S_DONE);

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] cap;
  logic [WORD_W-1:0] cap_nxt;
  logic [WC_W-1:0]   ccnt;
  logic [WC_W-1:0]   pad;

  assign cap_nxt = {cap[WORD_W-2:0], ccff_tail};
  assign pad     = WC_W'(WORD_W - 1) - ccnt;

  // A short final word is left-aligned by shifting out the stale upper bits.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      cap      <= '0;
      ccnt     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_SHIFT) begin
        if (last_bit || (ccnt == WC_W'(WORD_W - 1))) begin
          rd_valid <= 1'b1;
          rd_data  <= cap_nxt << pad;
          ccnt     <= '0;
        end else begin
          ccnt <= ccnt + WC_W'(1);
        end
        cap <= cap_nxt;
      end
    end
  end
`else
  logic unused_tail;

  assign unused_tail = ccff_tail;
  assign rd_data     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule
